// File: rtl/arb_pkg.sv
// Shared constants, state encoding and round-robin pick helper for the 10-way request arbiter.
package arb_pkg;

  localparam int NUM_REQ      = 10;
  localparam int IDX_W        = 4;
  localparam int MAX_HOLD_DEF = 255;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set request scanning ptr, ptr+1, ..., 9, 0, ..., ptr-1; returns one-hot or zero.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                                  input logic [IDX_W-1:0]   ptr);
    logic [NUM_REQ-1:0] pick;
    logic               found;
    int                 j;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_v[j]) begin
        pick[j] = 1'b1;
        found   = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/onehot10_to_bin4.sv
// Combinational 10-bit one-hot to 4-bit index; any non-one-hot input maps to 0.
module onehot10_to_bin4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot_i,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    idx_o = '0;
    case (onehot_i)
      10'b00_0000_0001: idx_o = 4'd0;
      10'b00_0000_0010: idx_o = 4'd1;
      10'b00_0000_0100: idx_o = 4'd2;
      10'b00_0000_1000: idx_o = 4'd3;
      10'b00_0001_0000: idx_o = 4'd4;
      10'b00_0010_0000: idx_o = 4'd5;
      10'b00_0100_0000: idx_o = 4'd6;
      10'b00_1000_0000: idx_o = 4'd7;
      10'b01_0000_0000: idx_o = 4'd8;
      10'b10_0000_0000: idx_o = 4'd9;
      default:          idx_o = 4'd0;
    endcase
  end

endmodule

// File: rtl/decimal_req_arbiter.sv
// Round-robin arbiter for 10 requesters; grant registered one edge after req, held until owner drops.
// ARB_TIMEOUT_EN builds a hold counter that force-releases a grant after MAX_HOLD cycles.
module decimal_req_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               timeout_q, timeout_d;
  logic               hold_hit;
  logic               hold_clr;

  onehot10_to_bin4 u_enc (
    .onehot_i (gnt_d),
    .idx_o    (gnt_idx_d)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q;

  // Counter reads MAX_HOLD-1 on the last allowed GRANT cycle, so the grant lasts MAX_HOLD cycles.
  assign hold_hit = (state_q == GRANT) && (hold_cnt_q == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if (hold_clr) begin
      hold_cnt_q <= '0;
    end else if (state_q == GRANT) begin
      hold_cnt_q <= hold_cnt_q + 8'd1;
    end
  end
`else
  logic unused_hold;
  assign hold_hit    = 1'b0;
  assign unused_hold = hold_clr ^ (MAX_HOLD != 0);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    hold_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          gnt_d    = rr_pick(req, ptr_q);
          state_d  = GRANT;
          hold_clr = 1'b1;
        end
      end
      GRANT: begin
        if (((req & gnt_q) == '0) || hold_hit) begin
          gnt_d     = '0;
          ptr_d     = (gnt_idx_q == 4'd9) ? 4'd0 : gnt_idx_q + 4'd1;
          state_d   = IDLE;
          timeout_d = hold_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= (gnt_d != '0);
      ptr_q       <= ptr_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
